// File: rtl/icb_arb_pkg.sv
// Shared types and helpers for the ICB round-robin arbiter.
// FSM state encoding, age counter width and a one-hot to index helper.
package icb_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    localparam int AGE_W = 8;

    // Index of the set bit of a one-hot vector (highest set bit if several).
    function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/icb_rr_pick.sv
// Rotating first-set picker: rotates the request vector so that bit ptr
// becomes bit 0, priority-encodes the lowest set bit and maps it back.
module icb_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;

    assign rot = N'({req, req} >> ptr);

    always_comb begin
        found = 1'b0;
        off   = '0;
        // Descending scan so the lowest set bit is the one left standing.
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                off   = IW'(j);
            end
        end
    end

    always_comb begin
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
        end
    end

    assign idx = sum[IW-1:0];

endmodule

// File: rtl/icb_rr_arbiter_n.sv
// N-port ICB arbiter: fixed-priority upper ports, round-robin lower ports,
// starvation ageing that lifts a starved RR port above the fixed ports.
module icb_rr_arbiter_n #(
    parameter int N_PORTS   = 5,
    parameter int N_FIXED   = 1,
    parameter int AGE_LIMIT = 8,
    parameter int RR_INIT   = 0,
    parameter int SEL_W     = $clog2(N_PORTS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arb_en,
    input  logic [N_PORTS-1:0] req,
    input  logic [N_PORTS-1:0] done,
    output logic [N_PORTS-1:0] grant,
    output logic [SEL_W-1:0]   icb_sel,
    output logic               busy
);
    import icb_arb_pkg::*;

    localparam int N_RR = N_PORTS - N_FIXED;
    localparam int PW   = (N_RR > 1) ? $clog2(N_RR) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

    arb_state_e         state_reg, state_next;
    logic [N_PORTS-1:0] grant_reg, grant_next;
    logic [SEL_W-1:0]   sel_reg, sel_next;
    logic [PW-1:0]      rr_ptr_reg, rr_ptr_next;
    logic [AGE_W-1:0]   age_reg [N_RR];

    logic [N_RR-1:0]    starved;
    logic               st_found, rr_found, fix_found;
    logic [PW-1:0]      st_idx, rr_idx, win_rr_idx, rr_ptr_inc;
    logic [PW:0]        inc_w;
    logic [SEL_W-1:0]   fix_idx, win_idx;
    logic               win_rr, owner_done, arb_ev;

    for (genvar gi = 0; gi < N_RR; gi++) begin : g_starved
        assign starved[gi] = (AGE_LIMIT > 0) && req[gi] && (age_reg[gi] == AGE_MAX);
    end

    icb_rr_pick #(.N(N_RR), .IW(PW)) u_pick_starved (
        .req   (starved),
        .ptr   (rr_ptr_reg),
        .found (st_found),
        .idx   (st_idx)
    );

    icb_rr_pick #(.N(N_RR), .IW(PW)) u_pick_rr (
        .req   (req[N_RR-1:0]),
        .ptr   (rr_ptr_reg),
        .found (rr_found),
        .idx   (rr_idx)
    );

    // Ascending scan: the highest requesting fixed port is the last written.
    always_comb begin
        fix_found = 1'b0;
        fix_idx   = '0;
        for (int i = N_RR; i < N_PORTS; i++) begin
            if (req[i]) begin
                fix_found = 1'b1;
                fix_idx   = SEL_W'(i);
            end
        end
    end

    assign win_rr     = st_found || (!fix_found && rr_found);
    assign win_rr_idx = st_found ? st_idx : rr_idx;
    assign win_idx    = win_rr ? SEL_W'(win_rr_idx) : fix_idx;

    assign inc_w      = {1'b0, win_rr_idx} + 1'b1;
    assign rr_ptr_inc = (inc_w == (PW + 1)'(N_RR)) ? '0 : inc_w[PW-1:0];

    assign owner_done = (state_reg == OWNED) && done[sel_reg];
    assign arb_ev     = arb_en && (|req) && ((state_reg == IDLE) || owner_done);

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        sel_next    = sel_reg;
        rr_ptr_next = rr_ptr_reg;
        if (arb_ev) begin
            state_next = OWNED;
            grant_next = {{(N_PORTS - 1){1'b0}}, 1'b1} << win_idx;
            sel_next   = win_idx;
            if (win_rr) begin
                rr_ptr_next = rr_ptr_inc;
            end
        end else if (owner_done) begin
            state_next = IDLE;
            grant_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            sel_reg    <= '0;
            rr_ptr_reg <= PW'(RR_INIT);
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            sel_reg    <= sel_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Idle ports forget their age; ages otherwise move only on arbitration events.
    for (genvar gi = 0; gi < N_RR; gi++) begin : g_age
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                age_reg[gi] <= '0;
            end else if (!req[gi]) begin
                age_reg[gi] <= '0;
            end else if (arb_ev) begin
                if (win_rr && (win_rr_idx == PW'(gi))) begin
                    age_reg[gi] <= '0;
                end else if (age_reg[gi] < AGE_MAX) begin
                    age_reg[gi] <= age_reg[gi] + 1'b1;
                end
            end
        end
    end

    assign grant   = grant_reg;
    assign icb_sel = sel_reg;
    assign busy    = |grant_reg;

    a_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant_reg));
    a_busy : assert property (@(posedge clk) disable iff (!rst_n)
        busy == (|grant_reg));
    a_sel : assert property (@(posedge clk) disable iff (!rst_n)
        busy |-> (4'(sel_reg) == onehot2idx(16'(grant_reg))));
    a_hold : assert property (@(posedge clk) disable iff (!rst_n)
        ((state_reg == OWNED) && !done[sel_reg]) |=> $stable(grant_reg));

endmodule

// File: tb/tb_icb_rr_arbiter_n.sv
// Randomized and directed bench for icb_rr_arbiter_n against a behavioural
// owner/pointer/age model.
module tb_icb_rr_arbiter_n;

    localparam int N_PORTS   = 5;
    localparam int N_FIXED   = 1;
    localparam int AGE_LIMIT = 4;
    localparam int RR_INIT   = 0;
    localparam int N_RR      = N_PORTS - N_FIXED;
    localparam int SEL_W     = $clog2(N_PORTS);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               arb_en;
    logic [N_PORTS-1:0] req;
    logic [N_PORTS-1:0] done;
    logic [N_PORTS-1:0] grant;
    logic [SEL_W-1:0]   icb_sel;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    int m_owner;
    int m_sel;
    int m_ptr;
    int m_age [N_RR];

    icb_rr_arbiter_n #(
        .N_PORTS   (N_PORTS),
        .N_FIXED   (N_FIXED),
        .AGE_LIMIT (AGE_LIMIT),
        .RR_INIT   (RR_INIT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .arb_en  (arb_en),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .icb_sel (icb_sel),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s txn=%0d got=%0d exp=%0d", tag, txn, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_sel   = 0;
        m_ptr   = RR_INIT;
        for (int q = 0; q < N_RR; q++) m_age[q] = 0;
    endtask

    task automatic model_update(input logic [N_PORTS-1:0] r, input logic [N_PORTS-1:0] d,
                                input logic en);
        int  w;
        int  p;
        bit  od;
        bit  ev;
        od = 1'b0;
        if (m_owner >= 0) od = d[m_owner];
        ev = en && (r != 0) && ((m_owner < 0) || od);
        if (ev) begin
            w = -1;
            if (AGE_LIMIT > 0) begin
                for (int k = 0; k < N_RR; k++) begin
                    p = (m_ptr + k) % N_RR;
                    if (w < 0 && r[p] && m_age[p] == AGE_LIMIT) w = p;
                end
            end
            for (int q = N_PORTS - 1; q >= N_RR; q--) begin
                if (w < 0 && r[q]) w = q;
            end
            for (int k = 0; k < N_RR; k++) begin
                p = (m_ptr + k) % N_RR;
                if (w < 0 && r[p]) w = p;
            end
            for (int q = 0; q < N_RR; q++) begin
                if (!r[q] || q == w) m_age[q] = 0;
                else if (m_age[q] < AGE_LIMIT) m_age[q] = m_age[q] + 1;
            end
            if (w < N_RR) m_ptr = (w + 1) % N_RR;
            m_owner = w;
            m_sel   = w;
        end else begin
            for (int q = 0; q < N_RR; q++) begin
                if (!r[q]) m_age[q] = 0;
            end
            if (od) m_owner = -1;
        end
    endtask

    task automatic compare_all();
        int exp_grant;
        exp_grant = (m_owner < 0) ? 0 : (1 << m_owner);
        chk("grant",   int'(grant),   exp_grant);
        chk("icb_sel", int'(icb_sel), m_sel);
        chk("busy",    int'(busy),    (m_owner < 0) ? 0 : 1);
        chk("rr_ptr",  int'(dut.rr_ptr_reg), m_ptr);
        for (int q = 0; q < N_RR; q++) begin
            chk("age", int'(dut.age_reg[q]), m_age[q]);
        end
    endtask

    task automatic step(input logic [N_PORTS-1:0] r, input logic [N_PORTS-1:0] d,
                        input logic en);
        req    = r;
        done   = d;
        arb_en = en;
        model_update(r, d, en);
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d req=%b done=%b en=%0d grant=%b sel=%0d busy=%0d",
                 txn, r, d, en, grant, icb_sel, busy);
        compare_all();
        done = '0;
    endtask

    initial begin
        logic [N_PORTS-1:0] r;
        logic [N_PORTS-1:0] d;
        logic               en;

        rst_n  = 1'b0;
        arb_en = 1'b1;
        req    = '0;
        done   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_sel",   int'(icb_sel), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_ptr",   int'(dut.rr_ptr_reg), RR_INIT);

        // Two RR requesters: port 1 then port 2 back-to-back.
        step(5'b00110, 5'b00000, 1'b1);
        chk("s1_grant", int'(grant), 5'b00010);
        chk("s1_sel",   int'(icb_sel), 1);
        step(5'b00110, 5'b00010, 1'b1);
        chk("s1_grant2", int'(grant), 5'b00100);
        chk("s1_ptr",    int'(dut.rr_ptr_reg), 3);
        step(5'b00000, 5'b00100, 1'b1);

        // Fixed port beats RR port; fixed grant leaves the pointer alone.
        step(5'b10001, 5'b00000, 1'b1);
        chk("s2_grant", int'(grant), 5'b10000);
        chk("s2_sel",   int'(icb_sel), 4);
        chk("s2_ptr",   int'(dut.rr_ptr_reg), 3);
        step(5'b00001, 5'b10000, 1'b1);
        chk("s2_grant2", int'(grant), 5'b00001);
        step(5'b00000, 5'b00001, 1'b1);

        // Ageing: port 2 loses four events to port 4, then jumps ahead.
        step(5'b10100, 5'b00000, 1'b1);
        step(5'b10100, 5'b00000, 1'b1);
        for (int i = 0; i < 3; i++) step(5'b10100, 5'b10000, 1'b1);
        chk("s3_age_sat", int'(dut.age_reg[2]), AGE_LIMIT);
        step(5'b10100, 5'b10000, 1'b1);
        chk("s3_grant", int'(grant), 5'b00100);
        chk("s3_age0",  int'(dut.age_reg[2]), 0);
        step(5'b00000, 5'b00100, 1'b1);

        // Owner drops req; foreign done ignored; own done releases.
        step(5'b01000, 5'b00000, 1'b1);
        step(5'b00001, 5'b00001, 1'b1);
        chk("s4_hold", int'(grant), 5'b01000);
        step(5'b00000, 5'b01000, 1'b1);
        chk("s4_grant", int'(grant), 0);
        chk("s4_busy",  int'(busy), 0);
        chk("s4_sel",   int'(icb_sel), 3);
        step(5'b00000, 5'b01000, 1'b1);

        // Arbitration disabled, then enabled.
        for (int i = 0; i < 3; i++) step(5'b11111, 5'b00000, 1'b0);
        chk("s5_off", int'(grant), 0);
        step(5'b11111, 5'b00000, 1'b1);
        chk("s5_on", int'(grant), 5'b10000);

        // Asynchronous reset mid-ownership.
        step(5'b00100, 5'b10000, 1'b1);
        chk("s6_pre", int'(grant), 5'b00100);
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("s6_grant", int'(grant), 0);
        chk("s6_busy",  int'(busy), 0);
        chk("s6_ptr",   int'(dut.rr_ptr_reg), 0);
        for (int q = 0; q < N_RR; q++) chk("s6_age", int'(dut.age_reg[q]), 0);
        req  = '0;
        done = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic, done biased toward the current owner.
        for (int i = 0; i < 3000; i++) begin
            r  = N_PORTS'($urandom);
            d  = '0;
            en = ($urandom_range(0, 9) != 0);
            if (m_owner >= 0 && $urandom_range(0, 2) == 0) d[m_owner] = 1'b1;
            if ($urandom_range(0, 7) == 0) d = d | N_PORTS'($urandom);
            step(r, d, en);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
